// File: rtl/time_setter_if.sv
// time_setter_if: target request, live timekeeper time and set pulses between time_setter and its environment.
interface time_setter_if;
  logic       AM_mode;
  logic       start;
  logic [5:0] tgt_hr;
  logic [5:0] tgt_min;
  logic       tgt_pm;
  logic [5:0] curr_hr;
  logic [5:0] curr_min;
  logic [5:0] curr_sec;
  logic       curr_AM_PM;
  logic       add_hour;
  logic       add_minute;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] step_count;
  modport master (
    input  AM_mode, start, tgt_hr, tgt_min, tgt_pm, curr_hr, curr_min, curr_sec, curr_AM_PM,
    output add_hour, add_minute, busy, done, error, step_count
  );
  modport slave (
    output AM_mode, start, tgt_hr, tgt_min, tgt_pm, curr_hr, curr_min, curr_sec, curr_AM_PM,
    input  add_hour, add_minute, busy, done, error, step_count
  );
endinterface

// File: rtl/time_setter.sv
// time_setter: pulses the timekeeper's add_minute/add_hour until the live time matches a target.
module time_setter #(
  parameter int MAX_STEPS = 200
) (
  input logic          clk,
  input logic          reset_n,
  time_setter_if.master bus
);
  typedef enum logic [1:0] {IDLE, CHECK, APPLY} state_t;
  state_t     state_q;
  logic       am_q, tgt_pm_q, add_hour_q, add_minute_q, busy_q, done_q, error_q;
  logic [5:0] tgt_hr_q, tgt_min_q;
  logic [7:0] step_q, step_d;
  logic       min_ok, hr_ok, tgt_bad, hold_off;
  always_comb begin
    min_ok   = bus.curr_min == tgt_min_q;
    hr_ok    = bus.curr_hr == tgt_hr_q && (!am_q || bus.curr_AM_PM == tgt_pm_q);
    tgt_bad  = bus.tgt_min > 6'd59 || (bus.AM_mode ? (bus.tgt_hr == 6'd0 || bus.tgt_hr > 6'd12)
                                                   : bus.tgt_hr > 6'd23);
    // a pulse landing on the sec==59 edge is lost and the natural carry races the compare
    hold_off = bus.curr_sec == 6'd58 || bus.curr_sec == 6'd59;
    step_d   = step_q + 8'd1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      am_q         <= 1'b0;
      tgt_pm_q     <= 1'b0;
      tgt_hr_q     <= '0;
      tgt_min_q    <= '0;
      step_q       <= '0;
      add_hour_q   <= 1'b0;
      add_minute_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      add_hour_q   <= 1'b0;
      add_minute_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          tgt_hr_q  <= bus.tgt_hr;
          tgt_min_q <= bus.tgt_min;
          tgt_pm_q  <= bus.tgt_pm;
          am_q      <= bus.AM_mode;
          step_q    <= '0;
          busy_q    <= !tgt_bad;
          error_q   <= tgt_bad;
          state_q   <= tgt_bad ? IDLE : CHECK;
        end
        CHECK: begin
          if (bus.AM_mode != am_q) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (hold_off) begin
            state_q <= CHECK;
          end else if (min_ok && hr_ok) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (step_q == 8'(MAX_STEPS)) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // minutes first: a 59->0 wrap carries into the hour
            add_minute_q <= !min_ok;
            add_hour_q   <= min_ok;
            step_q       <= step_d;
            state_q      <= APPLY;
          end
        end
        APPLY: state_q <= CHECK;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.add_hour   = add_hour_q;
  assign bus.add_minute = add_minute_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.step_count = step_q;
endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: time_setter against a behavioural timekeeper, table-driven with a scoreboard queue.
module tb_time_setter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  time_setter_if i1 ();
  time_setter_if i2 ();
  time_setter dut (.clk(clk), .reset_n(rst_n), .bus(i1.master));
  time_setter #(.MAX_STEPS(3)) dut2 (.clk(clk), .reset_n(rst_n), .bus(i2.master));
  typedef struct {
    logic am; int th, tm; logic tp;
    int ch, cm, cs; logic cp; logic tk;
    logic err; int steps, hp, mp, eh, em; logic ep;
  } vec_t;
  typedef struct {logic err; int steps, hp, mp, eh, em; logic ep;} exp_t;
  vec_t  tbl [12];
  exp_t  sb [$];
  int    n_chk = 0, n_fail = 0;
  int    hcnt = 0, mcnt = 0, m2cnt = 0, viol = 0;
  logic  prev = 1'b0, ld = 1'b1, tick = 1'b0;
  logic [18:0] tk_t, ld_t = '0;
  function automatic logic [6:0] hinc(input logic am, input logic [6:0] ph);
    logic p; logic [5:0] h;
    {p, h} = ph;
    if (am) begin
      if (h == 11) p = ~p;
      h = (h == 12) ? 6'd1 : h + 6'd1;
    end else h = (h == 23) ? 6'd0 : h + 6'd1;
    return {p, h};
  endfunction
  function automatic logic [18:0] adv(input logic am, input logic [18:0] t, input logic tk,
                                      input logic addm, input logic addh);
    logic [6:0] ph; logic [5:0] m, s;
    {ph, m, s} = t;
    if (tk) begin
      if (s == 59) begin
        s = 0;
        if (m == 59) begin m = 0; ph = hinc(am, ph); end else m = m + 6'd1;
      end else s = s + 6'd1;
    end
    if (addm && t[5:0] != 59) begin
      if (m == 59) begin m = 0; ph = hinc(am, ph); end else m = m + 6'd1;
    end
    if (addh) ph = hinc(am, ph);
    return {ph, m, s};
  endfunction
  always @(posedge clk) tk_t <= ld ? ld_t : adv(i1.AM_mode, tk_t, tick, i1.add_minute, i1.add_hour);
  assign i1.curr_AM_PM = tk_t[18];
  assign i1.curr_hr    = tk_t[17:12];
  assign i1.curr_min   = tk_t[11:6];
  assign i1.curr_sec   = tk_t[5:0];
  always @(negedge clk) begin
    if ((i1.add_hour & i1.add_minute) | ((i1.add_hour | i1.add_minute) & prev)) viol <= viol + 1;
    prev  <= i1.add_hour | i1.add_minute;
    hcnt  <= hcnt + int'(i1.add_hour);
    mcnt  <= mcnt + int'(i1.add_minute);
    m2cnt <= m2cnt + int'(i2.add_minute);
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic load_time(input logic am, input int h, input int m, input int s, input logic p);
    @(negedge clk);
    ld_t = {p, 6'(h), 6'(m), 6'(s)};
    ld = 1'b1;
    i1.AM_mode = am;
    @(negedge clk);
    ld = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    exp_t e;
    int h0, m0, v0, cyc;
    load_time(v.am, v.ch, v.cm, v.cs, v.cp);
    i1.tgt_hr = 6'(v.th); i1.tgt_min = 6'(v.tm); i1.tgt_pm = v.tp;
    sb.push_back('{v.err, v.steps, v.hp, v.mp, v.eh, v.em, v.ep});
    h0 = hcnt; m0 = mcnt; v0 = viol;
    i1.start = 1'b1; tick = v.tk;
    @(negedge clk);
    i1.start = 1'b0;
    chk("busy_after_start", i1.busy, int'(!v.err));
    cyc = 0;
    while (!(i1.done | i1.error) && cyc < 2000) begin @(negedge clk); cyc++; end
    e = sb.pop_front();
    chk("finished", int'(i1.done | i1.error), 1);
    chk("error", i1.error, e.err);
    chk("done", i1.done, int'(!e.err));
    chk("step_count", i1.step_count, e.steps);
    chk("hour_pulses", hcnt - h0, e.hp);
    chk("minute_pulses", mcnt - m0, e.mp);
    chk("pulse_spacing", viol - v0, 0);
    if (!e.err) begin
      chk("final_hr", i1.curr_hr, e.eh);
      chk("final_min", i1.curr_min, e.em);
      if (v.am) chk("final_pm", i1.curr_AM_PM, e.ep);
    end
    tick = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", int'(i1.done | i1.error), 0);
    chk("busy_after_end", i1.busy, 0);
  endtask
  initial begin
    int c;
    i1.AM_mode = 0; i1.start = 0; i1.tgt_hr = 0; i1.tgt_min = 0; i1.tgt_pm = 0;
    i2.AM_mode = 0; i2.start = 0; i2.tgt_hr = 10; i2.tgt_min = 10; i2.tgt_pm = 0;
    i2.curr_hr = 10; i2.curr_min = 0; i2.curr_sec = 0; i2.curr_AM_PM = 0;
    //          am th tm tp  ch cm cs cp tk err st hp mp eh em ep
    tbl[0]  = '{0, 10, 25, 0, 10, 20, 5, 0, 0, 0, 5, 0, 5, 10, 25, 0};
    tbl[1]  = '{0, 0, 3, 0, 22, 58, 0, 0, 0, 0, 6, 1, 5, 0, 3, 0};
    tbl[2]  = '{1, 12, 0, 1, 11, 0, 0, 0, 0, 0, 1, 1, 0, 12, 0, 1};
    tbl[3]  = '{0, 10, 20, 0, 10, 19, 57, 0, 1, 0, 0, 0, 0, 10, 20, 0};
    tbl[4]  = '{0, 24, 0, 0, 10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 5, 60, 0, 10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 5, 5, 0, 5, 5, 0, 0, 0, 0, 0, 0, 0, 5, 5, 0};
    tbl[8]  = '{1, 1, 30, 1, 12, 30, 0, 1, 0, 0, 1, 1, 0, 1, 30, 1};
    tbl[9]  = '{1, 3, 0, 1, 3, 0, 0, 0, 0, 0, 12, 12, 0, 3, 0, 1};
    tbl[10] = '{0, 23, 59, 0, 0, 0, 0, 0, 0, 0, 82, 23, 59, 23, 59, 0};
    tbl[11] = '{1, 13, 0, 0, 10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    #12;
    chk("reset_busy", i1.busy, 0);
    chk("reset_pulses", int'(i1.add_hour | i1.add_minute | i1.done | i1.error), 0);
    chk("reset_steps", i1.step_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) run_vec(tbl[i]);
    // mode change while busy
    load_time(0, 10, 20, 0, 0);
    i1.tgt_hr = 10; i1.tgt_min = 50; i1.start = 1;
    @(negedge clk);
    i1.start = 0;
    repeat (6) @(negedge clk);
    i1.AM_mode = 1;
    c = 0;
    while (!(i1.done | i1.error) && c < 100) begin @(negedge clk); c++; end
    chk("mode_change_error", i1.error, 1);
    chk("mode_change_done", i1.done, 0);
    i1.AM_mode = 0;
    // step limit on the MAX_STEPS=3 instance with a frozen timekeeper
    i2.start = 1;
    @(negedge clk);
    i2.start = 0;
    c = 0;
    while (!(i2.done | i2.error) && c < 100) begin @(negedge clk); c++; end
    chk("max_steps_error", i2.error, 1);
    chk("max_steps_count", i2.step_count, 3);
    chk("max_steps_pulses", m2cnt, 3);
    // asynchronous reset during a pulse
    load_time(0, 10, 20, 5, 0);
    i1.tgt_hr = 10; i1.tgt_min = 25; i1.start = 1;
    @(negedge clk);
    i1.start = 0;
    c = 0;
    while (!i1.add_minute && c < 20) begin @(negedge clk); c++; end
    chk("pulse_before_reset", i1.add_minute, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_add_minute", i1.add_minute, 0);
    chk("rst_busy", i1.busy, 0);
    chk("rst_done_error", int'(i1.done | i1.error), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", int'(i1.busy | i1.add_minute | i1.add_hour), 0);
    run_vec(tbl[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
